// File: rtl/mmu_feeder_if.sv
// mmu_feeder_if: operand streams in, systolic-array pins out.
// master = upstream/MMU side, slave = mmu_feeder.
interface mmu_feeder_if #(
  parameter int depth     = 4,
  parameter int bit_width = 8
);
  localparam int W = depth * bit_width;

  logic         wt_valid;
  logic         wt_ready;
  logic [W-1:0] wt_in;
  logic         act_valid;
  logic         act_ready;
  logic [W-1:0] act_in;
  logic         act_last;
  logic         control;
  logic [W-1:0] wt_arr;
  logic [W-1:0] data_arr;

  modport master (
    output wt_valid, wt_in,
    output act_valid, act_in, act_last,
    input  wt_ready, act_ready,
    input  control, wt_arr, data_arr
  );

  modport slave (
    input  wt_valid, wt_in,
    input  act_valid, act_in, act_last,
    output wt_ready, act_ready,
    output control, wt_arr, data_arr
  );
endinterface

// File: rtl/mmu_feeder.sv
// mmu_feeder: loads a weight tile, streams skewed activations,
// flushes the array and flags result rows for the systolic MMU.
// Ports: clk, rst (sync, active-high), bus (mmu_feeder_if.slave:
//   wt/act valid-ready streams, control/wt_arr/data_arr pins),
//   res_valid, busy, done, stall_cnt.
// Optional: define MMU_FEEDER_PERF_EN to build the stall counter.
module mmu_feeder #(
  parameter int depth     = 4,
  parameter int bit_width = 8,
  parameter int size      = 4,
  parameter int RES_LAT   = 5
) (
  input  logic         clk,
  input  logic         rst,
  mmu_feeder_if.slave  bus,
  output logic         res_valid,
  output logic         busy,
  output logic         done,
  output logic [15:0]  stall_cnt
);

  localparam int W         = depth * bit_width;
  localparam int FLUSH_LEN = depth - 1 + RES_LAT;
  localparam int WCW       = (depth > 2) ? $clog2(depth) : 1;
  localparam int FCW       = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;

  if (depth < 2) begin : g_chk_depth
    $error("mmu_feeder: depth must be at least 2");
  end
  if (size < 1) begin : g_chk_size
    $error("mmu_feeder: size must be at least 1");
  end
  if (RES_LAT < 1) begin : g_chk_lat
    $error("mmu_feeder: RES_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic               control_q, control_d;
  logic [W-1:0]       wt_arr_q, wt_arr_d;
  logic               done_q, done_d;
  logic [RES_LAT:0]   vld_q, vld_d;

  logic               wt_hs;
  logic               act_hs;
  logic               flush_end;
  logic [W-1:0]       row_in;
  logic [W-1:0]       data_w;

  // Readies depend on state only.
  assign bus.wt_ready  = (state_q == IDLE) || (state_q == LOAD_W);
  assign bus.act_ready = (state_q == STREAM);

  assign wt_hs  = bus.wt_valid && bus.wt_ready;
  assign act_hs = bus.act_valid && bus.act_ready;

  assign flush_end = (state_q == FLUSH) &&
                     (fcnt_q == FCW'(FLUSH_LEN - 1));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (wt_hs) begin
          state_d = LOAD_W;
          wcnt_d  = WCW'(1);
        end
      end
      LOAD_W: begin
        if (wt_hs) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (wcnt_q == WCW'(depth - 1)) begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (act_hs && bus.act_last) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      FLUSH: begin
        if (flush_end) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight beats go out one cycle after acceptance; gaps drive zeros.
  always_comb begin
    control_d = wt_hs;
    wt_arr_d  = wt_hs ? bus.wt_in : '0;
    done_d    = flush_end;
    vld_d     = {vld_q[RES_LAT-1:0], act_hs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      fcnt_q    <= '0;
      control_q <= 1'b0;
      wt_arr_q  <= '0;
      done_q    <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      fcnt_q    <= fcnt_d;
      control_q <= control_d;
      wt_arr_q  <= wt_arr_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
    end
  end

  // Bubbles, flush and idle cycles all push zeros into the skew lines.
  assign row_in = act_hs ? bus.act_in : '0;

  // Lane k: k+1 stage shift line, oldest entry in the top slot.
  for (genvar k = 0; k < depth; k++) begin : g_lane
    logic [(k+1)*bit_width-1:0] sr_q, sr_d;
    logic [bit_width-1:0]       lane_in;

    assign lane_in = row_in[k*bit_width +: bit_width];

    if (k == 0) begin : g_head
      always_comb sr_d = lane_in;
    end else begin : g_tail
      always_comb sr_d = {sr_q[k*bit_width-1:0], lane_in};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign data_w[k*bit_width +: bit_width] =
      sr_q[(k+1)*bit_width-1 -: bit_width];
  end

  assign bus.control  = control_q;
  assign bus.wt_arr   = wt_arr_q;
  assign bus.data_arr = data_w;
  assign res_valid    = vld_q[RES_LAT];
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

`ifdef MMU_FEEDER_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && wt_hs) begin
      stall_d = '0;
    end else if ((state_q == STREAM) && !bus.act_valid &&
                 (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
